// File: rtl/pio_in_edge_capture_if.sv
// ----------------------------------------------------------------------------
// pio_in_edge_capture_if
//
// Avalon-MM slave bus bundle for the parallel input port.
//
// Signals:
//   address     word address within the four-word slave window
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   32-bit write data
//   readdata    32-bit read data, combinational from address
//
// Modports:
//   master  bus initiator (interconnect / testbench)
//   slave   the PIO itself
// ----------------------------------------------------------------------------
interface pio_in_edge_capture_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface : pio_in_edge_capture_if

// File: rtl/pio_in_edge_capture.sv
// ----------------------------------------------------------------------------
// pio_in_edge_capture
//
// Avalon-MM slave parallel input port. Synchronizes an external WIDTH-bit bus,
// presents its level at word 0, captures configured edges per bit into a
// sticky register at word 3 and raises a maskable level interrupt.
//
// Register map (32-bit words):
//   0 DATA          RO  synchronized in_port, zero-extended
//   1 reserved      reads 0, writes ignored
//   2 IRQ_MASK      RW  WIDTH bits
//   3 EDGE_CAPTURE  sticky; cleared by write, a same-cycle edge wins
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high reset
//   bus      Avalon-MM slave (address, chipselect, write_n, writedata,
//            readdata)
//   in_port  external asynchronous input bus
//   irq      level interrupt, |(edge_capture & irq_mask)
//
// Parameters:
//   WIDTH        number of input bits (1..32)
//   EDGE_TYPE    0 rising, 1 falling, 2 any
//   SYNC_STAGES  synchronizer depth (2..4)
//
// Build option:
//   PIO_IN_BIT_CLEAR_EN  defined: writing EDGE_CAPTURE clears only the bits
//                        written as 1. Undefined: any write clears all bits.
// ----------------------------------------------------------------------------
module pio_in_edge_capture #(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   pio_in_edge_capture_if.slave       bus,
   input  logic [WIDTH-1:0]           in_port,
   output logic                       irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAP  = 2'd3;

   // Stage 0 samples in_port; the last stage is the synchronized value.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
   logic [WIDTH-1:0]                  sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0]                  edge_capture_q, edge_capture_d;

   logic                              wr_en;
   logic [WIDTH-1:0]                  edge_vec;
   logic [WIDTH-1:0]                  clear_vec;
   logic                              unused_wdata;

   assign sync_q       = sync_chain_q[SYNC_STAGES-1];
   assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], in_port};
   assign wr_en        = bus.chipselect & ~bus.write_n;

   // Upper writedata bits have no destination when WIDTH < 32.
   assign unused_wdata = ^bus.writedata;

   // Edge detection between the synchronized value and its one-cycle copy.
   always_comb begin
      if (EDGE_TYPE == 0) begin
         edge_vec = sync_q & ~prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_vec = ~sync_q & prev_q;
      end else begin
         edge_vec = sync_q ^ prev_q;
      end
   end

   // NOTE: every signal written in always_comb gets a default first so a
   // missing branch can never infer a latch.
   always_comb begin
      irq_mask_d = irq_mask_q;
      clear_vec  = '0;

      if (wr_en && bus.address == ADDR_MASK) begin
         irq_mask_d = bus.writedata[WIDTH-1:0];
      end

      if (wr_en && bus.address == ADDR_CAP) begin
`ifdef PIO_IN_BIT_CLEAR_EN
         clear_vec = bus.writedata[WIDTH-1:0];
`else
         clear_vec = '1;
`endif
      end

      // Clear first, then OR in new edges: a coincident edge survives.
      edge_capture_d = (edge_capture_q & ~clear_vec) | edge_vec;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours (the sync chain relies on it).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_chain_q   <= '0;
         prev_q         <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
      end else begin
         sync_chain_q   <= sync_chain_d;
         prev_q         <= sync_q;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
      end
   end

   // Read mux: combinational from address, independent of chipselect,
   // no side effects.
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA: bus.readdata[WIDTH-1:0] = sync_q;
         ADDR_MASK: bus.readdata[WIDTH-1:0] = irq_mask_q;
         ADDR_CAP:  bus.readdata[WIDTH-1:0] = edge_capture_q;
         default:   bus.readdata = '0;
      endcase
   end

   assign irq = |(edge_capture_q & irq_mask_q);

endmodule : pio_in_edge_capture

// File: tb/tb_pio_in_edge_capture.sv
// ----------------------------------------------------------------------------
// tb_pio_in_edge_capture
//
// Directed bench for pio_in_edge_capture. Two instances share clk/reset:
// dut0 captures rising edges, dut2 captures any edge. Inputs change on the
// falling clock edge; outputs are sampled just after it.
// ----------------------------------------------------------------------------
module tb_pio_in_edge_capture;

   logic       clk;
   logic       reset;
   logic [7:0] in0;
   logic [7:0] in2;
   logic       irq0;
   logic       irq2;

   int checks   = 0;
   int failures = 0;

   pio_in_edge_capture_if bus0 ();
   pio_in_edge_capture_if bus2 ();

   pio_in_edge_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus0),
      .in_port (in0),
      .irq     (irq0)
   );

   pio_in_edge_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus2),
      .in_port (in2),
      .irq     (irq2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Combinational read: settle 1 ns, then sample. Issued after a falling edge.
   task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] d);
      if (sel == 0) begin
         bus0.address = a;
         #1;
         d = bus0.readdata;
      end else begin
         bus2.address = a;
         #1;
         d = bus2.readdata;
      end
   endtask

   // One-cycle write: strobes are active across exactly one rising edge.
   task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
      if (sel == 0) begin
         bus0.address    = a;
         bus0.writedata  = d;
         bus0.chipselect = 1'b1;
         bus0.write_n    = 1'b0;
      end else begin
         bus2.address    = a;
         bus2.writedata  = d;
         bus2.chipselect = 1'b1;
         bus2.write_n    = 1'b0;
      end
      @(negedge clk);
      bus0.chipselect = 1'b0;
      bus0.write_n    = 1'b1;
      bus2.chipselect = 1'b0;
      bus2.write_n    = 1'b1;
   endtask

   logic [31:0] rdata;
   logic [31:0] exp_cap;
   logic        exp_irq;

   initial begin
      reset           = 1'b1;
      in0             = 8'h00;
      in2             = 8'h00;
      bus0.address    = 2'd0;
      bus0.chipselect = 1'b0;
      bus0.write_n    = 1'b1;
      bus0.writedata  = '0;
      bus2.address    = 2'd0;
      bus2.chipselect = 1'b0;
      bus2.write_n    = 1'b1;
      bus2.writedata  = '0;

      // ---- reset state ----
      tick(2);
      rd(0, 2'd0, rdata); check("rst_data", rdata, 32'h0);
      rd(0, 2'd2, rdata); check("rst_mask", rdata, 32'h0);
      rd(0, 2'd3, rdata); check("rst_cap",  rdata, 32'h0);
      check("rst_irq", {31'b0, irq0}, 32'h0);

      // ---- release reset, rising edges on bits 0 and 2 ----
      tick(1);
      reset = 1'b0;
      in0   = 8'h05;
      tick(1);
      rd(0, 2'd0, rdata); check("data_lat1", rdata, 32'h0);
      tick(1);
      rd(0, 2'd0, rdata); check("data_lat2", rdata, 32'h0000_0005);
      rd(0, 2'd3, rdata); check("cap_lat2",  rdata, 32'h0);
      tick(1);
      rd(0, 2'd3, rdata); check("cap_lat3",  rdata, 32'h0000_0005);
      check("irq_masked", {31'b0, irq0}, 32'h0);

      // ---- mask behaviour ----
      wr(0, 2'd2, 32'h0000_0004);
      check("irq_unmask", {31'b0, irq0}, 32'h1);
      rd(0, 2'd2, rdata); check("mask_rd", rdata, 32'h0000_0004);
      rd(0, 2'd3, rdata); check("cap_after_mask", rdata, 32'h0000_0005);
      wr(0, 2'd2, 32'h0000_0002);
      check("irq_remask", {31'b0, irq0}, 32'h0);

      // ---- capture clear ----
      wr(0, 2'd2, 32'h0000_0004);
      wr(0, 2'd3, 32'h0000_0001);
`ifdef PIO_IN_BIT_CLEAR_EN
      exp_cap = 32'h0000_0004;
      exp_irq = 1'b1;
`else
      exp_cap = 32'h0000_0000;
      exp_irq = 1'b0;
`endif
      rd(0, 2'd3, rdata); check("cap_clear", rdata, exp_cap);
      check("irq_after_clear", {31'b0, irq0}, {31'b0, exp_irq});

      // ---- ignored writes, reserved word, chipselect qualification ----
      wr(0, 2'd0, 32'hFFFF_FFFF);
      wr(0, 2'd1, 32'hFFFF_FFFF);
      bus0.address    = 2'd2;
      bus0.writedata  = 32'hFFFF_FFFF;
      bus0.write_n    = 1'b0;
      bus0.chipselect = 1'b0;
      tick(1);
      bus0.write_n    = 1'b1;
      rd(0, 2'd0, rdata); check("data_ro",   rdata, 32'h0000_0005);
      rd(0, 2'd1, rdata); check("rsvd_zero", rdata, 32'h0);
      rd(0, 2'd2, rdata); check("mask_cs",   rdata, 32'h0000_0004);
      rd(0, 2'd3, rdata); check("cap_kept",  rdata, exp_cap);

      // ---- rising-only instance ignores falling edges ----
      wr(0, 2'd3, 32'hFFFF_FFFF);
      rd(0, 2'd3, rdata); check("cap_clear_all", rdata, 32'h0);
      in0 = 8'h00;
      tick(4);
      rd(0, 2'd3, rdata); check("cap_no_fall", rdata, 32'h0);
      rd(0, 2'd0, rdata); check("data_low",    rdata, 32'h0);

      // ---- any-edge instance: bit 7 rise, clear, fall ----
      in2 = 8'h80;
      tick(4);
      rd(2, 2'd3, rdata); check("any_rise", rdata, 32'h0000_0080);
      wr(2, 2'd3, 32'hFFFF_FFFF);
      rd(2, 2'd3, rdata); check("any_clr1", rdata, 32'h0);
      in2 = 8'h00;
      tick(4);
      rd(2, 2'd3, rdata); check("any_fall", rdata, 32'h0000_0080);
      wr(2, 2'd3, 32'hFFFF_FFFF);
      rd(2, 2'd3, rdata); check("any_clr2", rdata, 32'h0);

      // Rise lands on the capture register at the third edge, the same edge
      // as the clear write: the set must win.
      in2 = 8'h80;
      tick(2);
      wr(2, 2'd3, 32'hFFFF_FFFF);
      rd(2, 2'd3, rdata); check("set_wins", rdata, 32'h0000_0080);
      wr(2, 2'd3, 32'hFFFF_FFFF);
      rd(2, 2'd3, rdata); check("any_clr3", rdata, 32'h0);

      // ---- reset mid-operation ----
      in0 = 8'hFF;
      tick(3);
      rd(0, 2'd3, rdata); check("cap_ff", rdata, 32'h0000_00FF);
      wr(0, 2'd2, 32'h0000_00FF);
      check("irq_pre_rst", {31'b0, irq0}, 32'h1);
      reset = 1'b1;
      #1;
      check("irq_in_rst", {31'b0, irq0}, 32'h0);
      rd(0, 2'd0, rdata); check("rst2_data", rdata, 32'h0);
      rd(0, 2'd2, rdata); check("rst2_mask", rdata, 32'h0);
      rd(0, 2'd3, rdata); check("rst2_cap",  rdata, 32'h0);

      // Release with bits high: the synchronizer ramps and captures them.
      tick(1);
      reset = 1'b0;
      in0   = 8'h81;
      tick(2);
      rd(0, 2'd0, rdata); check("rel_data", rdata, 32'h0000_0081);
      rd(0, 2'd3, rdata); check("rel_cap2", rdata, 32'h0);
      tick(1);
      rd(0, 2'd3, rdata); check("rel_cap3", rdata, 32'h0000_0081);
      check("rel_irq", {31'b0, irq0}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_pio_in_edge_capture
